// File: rtl/blackjack_pkg.sv
// Shared types and defaults for the blackjack round sequencer.
package blackjack_pkg;

  localparam int BUST_LIMIT_DEF   = 21;
  localparam int DEALER_STAND_DEF = 17;

  typedef enum logic [3:0] {
    IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2,
    PLAYER, P_DRAW, DEALER, D_DRAW, DONE
  } state_t;

  typedef enum logic [2:0] {
    RES_NONE  = 3'd0,
    RES_WIN   = 3'd1,
    RES_LOSE  = 3'd2,
    RES_PUSH  = 3'd3,
    RES_BUST  = 3'd4,
    RES_DBUST = 3'd5
  } result_t;

  // Out-of-range card codes count as ten-valued cards.
  function automatic logic [4:0] card_norm(input logic [3:0] v);
    if (v == 4'd0 || v > 4'd10) return 5'd10;
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/hand_accum.sv
// One hand's running total; with SOFT_ACE_EN defined it also tracks a held ace
// and reports the soft (+10) value when that does not bust.
module hand_accum
  import blackjack_pkg::*;
#(
  parameter int BUST_LIMIT = BUST_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add,
  input  logic [3:0] card_val,
  output logic [4:0] value,
  output logic [4:0] value_next
);

  localparam logic [5:0] LIMIT = 6'(BUST_LIMIT);

  logic [4:0] raw;
  logic [4:0] raw_sum;
  logic [4:0] card;

  function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[5] ? 5'd31 : s[4:0];
  endfunction

  assign card    = card_norm(card_val);
  assign raw_sum = sat_add(raw, card);

  always_ff @(posedge clk) begin
    if (rst || clr) raw <= '0;
    else if (add)   raw <= raw_sum;
  end

`ifdef SOFT_ACE_EN
  logic ace;
  logic ace_sum;

  function automatic logic [4:0] soft_value(input logic [4:0] r, input logic a);
    logic [5:0] lifted;
    lifted = {1'b0, r} + 6'd10;
    return (a && lifted <= LIMIT) ? lifted[4:0] : r;
  endfunction

  assign ace_sum = ace | (card == 5'd1);

  always_ff @(posedge clk) begin
    if (rst || clr) ace <= 1'b0;
    else if (add)   ace <= ace_sum;
  end

  assign value      = soft_value(raw, ace);
  assign value_next = add ? soft_value(raw_sum, ace_sum) : value;
`else
  assign value      = raw;
  assign value_next = add ? raw_sum : raw;
`endif

endmodule

// File: rtl/round_sequencer.sv
// Blackjack round controller: deals, runs player and dealer turns over a card
// req/ack handshake and scores the round. Soft aces are enabled by SOFT_ACE_EN.
module round_sequencer
  import blackjack_pkg::*;
#(
  parameter int BUST_LIMIT   = BUST_LIMIT_DEF,
  parameter int DEALER_STAND = DEALER_STAND_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Deal,
  input  logic       Hit,
  input  logic       Stay,
  output logic       card_req,
  input  logic       card_ack,
  input  logic [3:0] card_val,
  output logic [4:0] player_hand,
  output logic [4:0] dealer_hand,
  output logic       busy,
  output logic [2:0] result
);

  localparam logic [4:0] LIMIT = 5'(BUST_LIMIT);
  localparam logic [4:0] STAND = 5'(DEALER_STAND);

  state_t     state, state_n;
  result_t    res, res_n;
  logic       hit_q;
  logic       gap_q;
  logic       card_state;
  logic       accept;
  logic       hit_edge;
  logic       clr;
  logic       p_add, d_add;
  logic [4:0] p_next, d_next;

  function automatic result_t judge(input logic [4:0] p, input logic [4:0] d);
    if (d > LIMIT)   return RES_DBUST;
    else if (p > d)  return RES_WIN;
    else if (p == d) return RES_PUSH;
    else             return RES_LOSE;
  endfunction

  // gap_q forces one idle request cycle after every accepted card, including
  // between back-to-back deal states.
  assign card_state = state inside {DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, P_DRAW, D_DRAW};
  assign card_req   = card_state & ~gap_q;
  assign accept     = card_req & card_ack;
  assign hit_edge   = Hit & ~hit_q;
  assign clr        = (state == IDLE || state == DONE) & Deal;
  assign p_add      = accept & (state inside {DEAL_P1, DEAL_P2, P_DRAW});
  assign d_add      = accept & (state inside {DEAL_D1, DEAL_D2, D_DRAW});
  assign busy       = !(state == IDLE || state == DONE);
  assign result     = res;

  hand_accum #(.BUST_LIMIT(BUST_LIMIT)) u_player (
    .clk       (Clock),
    .rst       (Reset),
    .clr       (clr),
    .add       (p_add),
    .card_val  (card_val),
    .value     (player_hand),
    .value_next(p_next)
  );

  hand_accum #(.BUST_LIMIT(BUST_LIMIT)) u_dealer (
    .clk       (Clock),
    .rst       (Reset),
    .clr       (clr),
    .add       (d_add),
    .card_val  (card_val),
    .value     (dealer_hand),
    .value_next(d_next)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      res   <= RES_NONE;
      hit_q <= 1'b0;
      gap_q <= 1'b0;
    end else begin
      state <= state_n;
      res   <= res_n;
      hit_q <= Hit;
      gap_q <= accept;
    end
  end

  always_comb begin
    state_n = state;
    res_n   = res;
    case (state)
      IDLE, DONE: begin
        if (Deal) begin
          state_n = DEAL_P1;
          res_n   = RES_NONE;
        end
      end
      DEAL_P1: if (accept) state_n = DEAL_D1;
      DEAL_D1: if (accept) state_n = DEAL_P2;
      DEAL_P2: if (accept) state_n = DEAL_D2;
      DEAL_D2: if (accept) state_n = PLAYER;
      PLAYER: begin
        if (Stay)                                  state_n = DEALER;
        else if (hit_edge && player_hand < LIMIT)  state_n = P_DRAW;
      end
      P_DRAW: begin
        // p_next already includes the card being accepted this cycle.
        if (accept) begin
          if (p_next > LIMIT) begin
            state_n = DONE;
            res_n   = RES_BUST;
          end else begin
            state_n = PLAYER;
          end
        end
      end
      DEALER: begin
        if (d_next < STAND) begin
          state_n = D_DRAW;
        end else begin
          state_n = DONE;
          res_n   = judge(p_next, d_next);
        end
      end
      D_DRAW:  if (accept) state_n = DEALER;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed rounds plus random decks, scored by a
// card-list reference model of the blackjack rules.
module tb_round_sequencer;

  localparam int BL = 21;
  localparam int DS = 17;

  logic       Clock = 1'b0;
  logic       Reset, Deal, Hit, Stay, card_ack;
  logic [3:0] card_val;
  logic       card_req, busy;
  logic [4:0] player_hand, dealer_hand;
  logic [2:0] result;

  int vectors    = 0;
  int miscompares = 0;
  int deck[$];
  int pc[$];
  int dc[$];

  always #5 Clock = ~Clock;

  round_sequencer #(.BUST_LIMIT(BL), .DEALER_STAND(DS)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Deal       (Deal),
    .Hit        (Hit),
    .Stay       (Stay),
    .card_req   (card_req),
    .card_ack   (card_ack),
    .card_val   (card_val),
    .player_hand(player_hand),
    .dealer_hand(dealer_hand),
    .busy       (busy),
    .result     (result)
  );

  function automatic int norm(int v);
    return (v == 0 || v > 10) ? 10 : v;
  endfunction

  // Value of a hand from its list of cards.
  function automatic int hand(bit dealer);
    int q[$];
    int s;
    s = 0;
    q = dealer ? dc : pc;
    foreach (q[i]) s += norm(q[i]);
`ifdef SOFT_ACE_EN
    foreach (q[i]) if (q[i] == 1 && s + 10 <= BL) begin s += 10; break; end
`endif
    return s;
  endfunction

  function automatic int expect_result();
    int p, d;
    p = hand(0);
    d = hand(1);
    if (p > BL) return 4;
    if (d > BL) return 5;
    if (p > d)  return 1;
    if (p == d) return 3;
    return 2;
  endfunction

  function automatic int draw();
    if (deck.size() > 0) return deck.pop_front();
    return int'($urandom_range(0, 15));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic give_card(input int v);
    int n;
    int dly;
    n = 0;
    while (card_req !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 20) begin
      check("card_req_wait", {7'd0, card_req}, 8'd1);
      return;
    end
    dly = int'($urandom_range(0, 2));
    repeat (dly) begin
      @(negedge Clock);
      check("req_hold", {7'd0, card_req}, 8'd1);
    end
    card_ack = 1'b1;
    card_val = 4'(v);
    @(negedge Clock);
    card_ack = 1'b0;
    card_val = 4'($urandom_range(0, 15));
    check("req_drop", {7'd0, card_req}, 8'd0);
    if ($urandom_range(0, 1) == 1) begin
      card_ack = 1'b1;
      @(negedge Clock);
      card_ack = 1'b0;
    end
  endtask

  task automatic play(input int nhits, input bit hold, input bit both, input bit dealp);
    int v;
    int n;
    pc.delete();
    dc.delete();
    Deal = 1'b1;
    @(negedge Clock);
    Deal = 1'b0;
    check("clr_player", 8'(player_hand), 8'd0);
    check("clr_dealer", 8'(dealer_hand), 8'd0);
    check("clr_result", 8'(result), 8'd0);
    check("busy_deal", {7'd0, busy}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      v = draw();
      give_card(v);
      if (i % 2 == 0) pc.push_back(v);
      else            dc.push_back(v);
    end
    check("deal_player", 8'(player_hand), 8'(hand(0)));
    check("deal_dealer", 8'(dealer_hand), 8'(hand(1)));
    if (dealp) begin
      Deal = 1'b1;
      @(negedge Clock);
      Deal = 1'b0;
      @(negedge Clock);
      check("deal_ignored_player", 8'(player_hand), 8'(hand(0)));
      check("deal_ignored_busy", {7'd0, busy}, 8'd1);
      check("deal_ignored_req", {7'd0, card_req}, 8'd0);
    end
    for (int i = 0; i < nhits; i++) begin
      if (hand(0) >= BL) begin
        Hit = 1'b1;
        @(negedge Clock);
        Hit = 1'b0;
        repeat (2) begin
          @(negedge Clock);
          check("hit_ignored", {7'd0, card_req}, 8'd0);
        end
        break;
      end
      Hit = 1'b1;
      if (!hold) begin
        @(negedge Clock);
        Hit = 1'b0;
      end
      v = draw();
      give_card(v);
      pc.push_back(v);
      check("hit_player", 8'(player_hand), 8'(hand(0)));
      if (hold) begin
        repeat (4) begin
          @(negedge Clock);
          check("hold_one_draw", {7'd0, card_req}, 8'd0);
        end
        Hit = 1'b0;
      end
      @(negedge Clock);
      if (hand(0) > BL) begin
        check("bust_result", 8'(result), 8'd4);
        check("bust_busy", {7'd0, busy}, 8'd0);
        repeat (3) begin
          @(negedge Clock);
          check("bust_no_req", {7'd0, card_req}, 8'd0);
        end
        check("bust_dealer", 8'(dealer_hand), 8'(hand(1)));
        check("bust_player", 8'(player_hand), 8'(hand(0)));
        return;
      end
    end
    if (both) Hit = 1'b1;
    Stay = 1'b1;
    @(negedge Clock);
    Stay = 1'b0;
    Hit  = 1'b0;
    while (hand(1) < DS) begin
      v = draw();
      give_card(v);
      dc.push_back(v);
    end
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check("done_busy", {7'd0, busy}, 8'd0);
    check("final_player", 8'(player_hand), 8'(hand(0)));
    check("final_dealer", 8'(dealer_hand), 8'(hand(1)));
    check("final_result", 8'(result), 8'(expect_result()));
    check("final_req", {7'd0, card_req}, 8'd0);
    repeat (2) @(negedge Clock);
    check("result_hold", 8'(result), 8'(expect_result()));
  endtask

  initial begin
    int n;
    Reset    = 1'b1;
    Deal     = 1'b0;
    Hit      = 1'b0;
    Stay     = 1'b0;
    card_ack = 1'b0;
    card_val = 4'd0;
    repeat (2) @(negedge Clock);
    check("rst_req", {7'd0, card_req}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_player", 8'(player_hand), 8'd0);
    check("rst_dealer", 8'(dealer_hand), 8'd0);
    check("rst_result", 8'(result), 8'd0);
    Reset = 1'b0;
    @(negedge Clock);

    card_ack = 1'b1;
    card_val = 4'd9;
    @(negedge Clock);
    card_ack = 1'b0;
    @(negedge Clock);
    check("idle_ack_player", 8'(player_hand), 8'd0);
    check("idle_ack_busy", {7'd0, busy}, 8'd0);

    deck = {10, 6, 7, 10, 5};
    play(0, 0, 0, 0);
    deck = {10, 9, 8, 10, 5};
    play(1, 1, 0, 0);
    deck = {9, 10, 9, 7};
    play(0, 0, 1, 0);
    deck = {9, 10, 9, 6, 10};
    play(0, 0, 1, 0);

    Deal = 1'b1;
    @(negedge Clock);
    Deal = 1'b0;
    give_card(5);
    n = 0;
    while (card_req !== 1'b1 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check("mid_req_seen", {7'd0, card_req}, 8'd1);
    card_ack = 1'b1;
    card_val = 4'd4;
    Reset    = 1'b1;
    @(negedge Clock);
    card_ack = 1'b0;
    Reset    = 1'b0;
    check("mid_rst_req", {7'd0, card_req}, 8'd0);
    check("mid_rst_player", 8'(player_hand), 8'd0);
    check("mid_rst_dealer", 8'(dealer_hand), 8'd0);
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    check("mid_rst_result", 8'(result), 8'd0);
    @(negedge Clock);

    deck = {1, 10, 6, 1, 6};
    play(0, 0, 0, 0);
    deck = {13, 5, 4, 6};
    play(0, 0, 0, 1);
    deck = {10, 5, 10, 6, 1};
    play(2, 0, 0, 0);

    for (int r = 0; r < 25; r++) begin
      deck.delete();
      play(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
